dmem_arbiter: RTL and testbench

- Two-requester arbiter and sequencer for the single-port data memory (1 read/1 write port, write-enable, combinational read) in the multi-cycle processor.
- Port 0 is instruction fetch and port 1 is load/store. Each requester uses a req/ack handshake.
- The arbiter grants one requester at a time (round-robin) and drives the memory's write, write-data and address inputs from registers.
- It returns registered read data to the granted requester.

---
 rtl/dmem_arbiter.sv | 139 +++++++++++++
 tb/tb_dmem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter/sequencer for the single-port data memory (port 0 fetch, port 1 load/store).
// Optional grant statistics counters are enabled with `define DMEM_ARB_STATS_EN.
module dmem_arbiter #(
  parameter int width = 32,
  parameter int depth = 32,
  localparam int AW = $clog2(depth)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             we0,
  input  logic [AW-1:0]    addr0,
  input  logic [width-1:0] wdata0,
  output logic             ack0,
  input  logic             req1,
  input  logic             we1,
  input  logic [AW-1:0]    addr1,
  input  logic [width-1:0] wdata1,
  output logic             ack1,
  output logic [width-1:0] rdata,
  output logic             mem_write,
  output logic [width-1:0] mem_wIn,
  output logic [AW-1:0]    mem_din,
  input  logic [width-1:0] mem_dout,
  output logic             busy,
  output logic             grant_id
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]      grant_cnt0,
  output logic [15:0]      grant_cnt1
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state;
  state_t next_state;
  logic   grant_valid;
  logic   grant_port;
  logic   mem_write_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // On a tie the port that did not win last time is chosen, so neither side can starve.
  always_comb begin
    next_state  = state;
    grant_valid = 1'b0;
    grant_port  = grant_id;
    case (state)
      IDLE: begin
        if (req0 && req1) begin
          grant_valid = 1'b1;
          grant_port  = ~grant_id;
        end else if (req0) begin
          grant_valid = 1'b1;
          grant_port  = 1'b0;
        end else if (req1) begin
          grant_valid = 1'b1;
          grant_port  = 1'b1;
        end
        if (grant_valid) begin
          next_state = ACCESS;
        end
      end
      ACCESS:  next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    ack0 = 1'b0;
    ack1 = 1'b0;
    case (state)
      ACCESS: busy = 1'b1;
      DONE: begin
        busy = 1'b1;
        ack0 = ~grant_id;
        ack1 = grant_id;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // rdata samples the memory on the same edge a write commits, giving read-before-write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant_id      <= 1'b1;
      mem_din       <= '0;
      mem_wIn       <= '0;
      mem_write_reg <= 1'b0;
      rdata         <= '0;
    end else begin
      if (state == IDLE && grant_valid) begin
        grant_id      <= grant_port;
        mem_din       <= grant_port ? addr1 : addr0;
        mem_wIn       <= grant_port ? wdata1 : wdata0;
        mem_write_reg <= grant_port ? we1 : we0;
      end
      if (state == ACCESS) begin
        rdata         <= mem_dout;
        mem_write_reg <= 1'b0;
      end
    end
  end

  // Masking with rst_n keeps a reset edge from committing a half-finished write.
  assign mem_write = mem_write_reg & rst_n;

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else if (state == DONE) begin
      if (!grant_id && grant_cnt0 != 16'hFFFF) begin
        grant_cnt0 <= grant_cnt0 + 16'd1;
      end
      if (grant_id && grant_cnt1 != 16'hFFFF) begin
        grant_cnt1 <= grant_cnt1 + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: transaction-level model plus directed scenarios.
// Build with DMEM_ARB_STATS_EN defined to also check the grant counters.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0, we0, req1, we1;
  logic [4:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        ack0, ack1;
  logic [31:0] rdata;
  logic        mem_write;
  logic [31:0] mem_wIn;
  logic [4:0]  mem_din;
  logic [31:0] mem_dout;
  logic        busy;
  logic        grant_id;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] grant_cnt0, grant_cnt1;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  dmem_arbiter #(.width(32), .depth(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
    .rdata(rdata), .mem_write(mem_write), .mem_wIn(mem_wIn), .mem_din(mem_din),
    .mem_dout(mem_dout), .busy(busy), .grant_id(grant_id)
`ifdef DMEM_ARB_STATS_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] initWord(input int i);
    if (i == 5) return 32'd33;
    if (i == 7) return 32'h0000_0077;
    return 32'h100 + i;
  endfunction

  function automatic void checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endfunction

  // Single-port memory with combinational read; loads its initial image on the first edge.
  logic [31:0] ram [32];
  bit          ramLoaded;
  always @(posedge clk) begin
    if (!ramLoaded) begin
      for (int i = 0; i < 32; i++) ram[i] <= initWord(i);
      ramLoaded <= 1'b1;
    end else if (mem_write) begin
      ram[mem_din] <= mem_wIn;
    end
  end
  assign mem_dout = ram[mem_din];

  // Transaction model: one access in flight, acked two edges after its grant, memory updated at the commit edge.
  logic [31:0] refMem [32];
  bit          modelReady;
  bit          inFlight;
  int          age;
  bit          tPort, tWe;
  logic [4:0]  tAddr;
  logic [31:0] tData;
  bit          lastPort;
  logic [31:0] expRdata, expWdata;
  logic [4:0]  expAddr;
  int          cnt0, cnt1;

  always @(posedge clk) begin
    cyc++;
    if (!modelReady) begin
      for (int i = 0; i < 32; i++) refMem[i] = initWord(i);
      modelReady = 1'b1;
    end
    if (!rst_n) begin
      inFlight = 1'b0; age = 0; lastPort = 1'b1;
      expRdata = '0; expWdata = '0; expAddr = '0; cnt0 = 0; cnt1 = 0;
    end else if (inFlight) begin
      age++;
      if (age == 1) begin
        expRdata = refMem[tAddr];
        if (tWe) refMem[tAddr] = tData;
      end else begin
        if (tPort == 1'b0 && cnt0 < 65535) cnt0++;
        if (tPort == 1'b1 && cnt1 < 65535) cnt1++;
        inFlight = 1'b0;
      end
    end else if (req0 || req1) begin
      tPort    = (req0 && req1) ? !lastPort : req1;
      tWe      = tPort ? we1 : we0;
      tAddr    = tPort ? addr1 : addr0;
      tData    = tPort ? wdata1 : wdata0;
      expAddr  = tAddr;
      expWdata = tData;
      lastPort = tPort;
      inFlight = 1'b1;
      age      = 0;
    end
  end

  always @(negedge clk) begin
    if (modelReady) begin
      checkOutput("ack0", ack0, inFlight && age == 1 && tPort == 1'b0);
      checkOutput("ack1", ack1, inFlight && age == 1 && tPort == 1'b1);
      checkOutput("busy", busy, inFlight);
      checkOutput("grant_id", grant_id, lastPort);
      checkOutput("rdata", rdata, expRdata);
      checkOutput("mem_din", mem_din, expAddr);
      checkOutput("mem_wIn", mem_wIn, expWdata);
      checkOutput("mem_write", mem_write, inFlight && age == 0 && tWe && rst_n);
`ifdef DMEM_ARB_STATS_EN
      checkOutput("grant_cnt0", grant_cnt0, cnt0);
      checkOutput("grant_cnt1", grant_cnt1, cnt1);
`endif
    end
  end

  int ackQ[$];
  always @(negedge clk) begin
    if (ack0) ackQ.push_back(0);
    if (ack1) ackQ.push_back(1);
  end

  // Called just after a rising edge; returns just after the rising edge that ends the ack cycle.
  task automatic applyStimulus(input bit p, input bit we, input logic [4:0] a, input logic [31:0] d,
                               output logic [31:0] rd, output int lat);
    int  start;
    bit  got;
    if (!p) begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
    else    begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
    start = cyc;
    got = 1'b0;
    rd = '0;
    lat = -1;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if ((!p && ack0) || (p && ack1)) begin
        got = 1'b1;
        rd = rdata;
        lat = cyc - start;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("[TB] FAIL ack timeout port%0d: got no ack expected ack within 30 cycles", p);
    end
    @(posedge clk);
    #1;
    if (!p) req0 = 1'b0; else req1 = 1'b0;
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [31:0] rdA, rdB;
  int          latA, latB;

  initial begin
    rst_n = 1'b0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    @(posedge clk);
    #1;
    resetDut();
    @(negedge clk);
    checkOutput("reset grant_id", grant_id, 1'b1);
    checkOutput("reset rdata", rdata, 32'h0);
    checkOutput("reset busy", busy, 1'b0);
    @(posedge clk);
    #1;

    $display("[TB] single read of word 5 on port 1");
    applyStimulus(1'b1, 1'b0, 5'd5, 32'h0, rdA, latA);
    checkOutput("read5 rdata", rdA, 32'd33);
    checkOutput("read5 latency", latA, 32'd2);

    $display("[TB] write then read of word 7 on port 0");
    applyStimulus(1'b0, 1'b1, 5'd7, 32'hDEADBEEF, rdA, latA);
    checkOutput("write7 old data", rdA, 32'h0000_0077);
    applyStimulus(1'b0, 1'b0, 5'd7, 32'h0, rdA, latA);
    checkOutput("read7 new data", rdA, 32'hDEADBEEF);

    $display("[TB] simultaneous requests after reset");
    resetDut();
    ackQ.delete();
    fork
      applyStimulus(1'b0, 1'b0, 5'd1, 32'h0, rdA, latA);
      applyStimulus(1'b1, 1'b0, 5'd2, 32'h0, rdB, latB);
    join
    checkOutput("tie port0 latency", latA, 32'd2);
    checkOutput("tie port1 latency", latB, 32'd5);
    checkOutput("tie ack count", ackQ.size(), 32'd2);
    if (ackQ.size() == 2) begin
      checkOutput("tie first ack", ackQ[0], 32'd0);
      checkOutput("tie second ack", ackQ[1], 32'd1);
    end
    checkOutput("tie port0 rdata", rdA, 32'h101);
    checkOutput("tie port1 rdata", rdB, 32'h102);

    $display("[TB] sustained contention");
    resetDut();
    ackQ.delete();
    fork
      begin
        logic [31:0] r;
        int l;
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 5'(10 + i), 32'h0, r, l);
      end
      begin
        logic [31:0] r;
        int l;
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 5'(20 + i), 32'h0, r, l);
      end
    join
    checkOutput("contention ack count", ackQ.size(), 32'd6);
    for (int i = 0; i < ackQ.size() && i < 6; i++) begin
      checkOutput("contention ack order", ackQ[i], i % 2);
    end
`ifdef DMEM_ARB_STATS_EN
    checkOutput("stats cnt0", grant_cnt0, 16'd3);
    checkOutput("stats cnt1", grant_cnt1, 16'd3);
    resetDut();
    @(negedge clk);
    checkOutput("stats cnt0 reset", grant_cnt0, 16'd0);
    checkOutput("stats cnt1 reset", grant_cnt1, 16'd0);
    @(posedge clk);
    #1;
`endif

    $display("[TB] reset during ACCESS of a port 1 write");
    req1 = 1'b1; we1 = 1'b1; addr1 = 5'd3; wdata1 = 32'h1234;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midrst busy in access", busy, 1'b1);
    checkOutput("midrst mem_write masked", mem_write, 1'b0);
    @(posedge clk);
    #1;
    req1 = 1'b0;
    @(negedge clk);
    checkOutput("midrst ack1", ack1, 1'b0);
    checkOutput("midrst busy", busy, 1'b0);
    checkOutput("midrst rdata", rdata, 32'h0);
    checkOutput("midrst grant_id", grant_id, 1'b1);
    checkOutput("midrst mem_din", mem_din, 5'd0);
    checkOutput("midrst mem_wIn", mem_wIn, 32'h0);
    checkOutput("midrst ram3", ram[3], 32'h0000_0103);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("midrst ram3 later", ram[3], 32'h0000_0103);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation did not finish");
  end

endmodule
